// File: rtl/bpred_tracker.sv
// rtl/bpred_tracker.sv - in-flight branch tracker between fetch, execute and the 1-bit predictor
// Optional statistics counters are built only when BPRED_TRACKER_STATS_EN is defined.
module bpred_tracker #(
    parameter int PCWIDTH   = 32,
    parameter int DEPTH     = 4,
    parameter int LOG2DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 fetch_branch,
    input  logic [PCWIDTH-1:0]   fetch_pc,
    output logic                 stall_fetch,
    output logic                 pred_valid,
    output logic                 pred_taken,
    input  logic                 resolve_valid,
    input  logic                 resolve_taken,
    input  logic                 squash,
    output logic                 mispredict,
    output logic                 err_underflow,
    output logic                 bp_predict,
    output logic [PCWIDTH-1:0]   bp_pc_predict,
    input  logic                 bp_prediction,
    output logic                 bp_result_rdy,
    output logic                 bp_result,
    output logic [PCWIDTH-1:0]   bp_pc_result,
    output logic [15:0]          stat_branches,
    output logic [15:0]          stat_mispredicts
);
    localparam int CW = LOG2DEPTH + 1;

    logic [PCWIDTH-1:0]   fifo_pc [DEPTH];
    logic [DEPTH-1:0]     fifo_pred;
    logic [LOG2DEPTH-1:0] head;
    logic [LOG2DEPTH-1:0] tail;
    logic [CW-1:0]        count;
    logic                 pend_v;
    logic [PCWIDTH-1:0]   pend_pc;

    logic [CW-1:0]        occ;
    logic                 fifo_empty;
    logic                 accept;
    logic                 resolve_ok;
    logic                 pop;
    logic                 bypass;
    logic                 push;
    logic [PCWIDTH-1:0]   entry_pc;
    logic                 entry_pred;
    logic [LOG2DEPTH-1:0] head_nxt;
    logic [LOG2DEPTH-1:0] tail_nxt;

    assign occ           = count + CW'(pend_v);
    assign fifo_empty    = (count == '0);
    assign stall_fetch   = (occ >= CW'(DEPTH));
    assign accept        = fetch_branch & ~stall_fetch & ~squash;
    assign bp_predict    = accept;
    assign bp_pc_predict = fetch_pc;
    assign pred_valid    = pend_v;
    assign pred_taken    = bp_prediction;

    // With the FIFO empty the oldest branch is the pending one, whose prediction is still on the wire.
    assign resolve_ok = resolve_valid & (occ != '0);
    assign pop        = resolve_ok & ~fifo_empty;
    assign bypass     = resolve_ok & fifo_empty;
    assign push       = pend_v & ~bypass & ~squash;
    assign entry_pc   = fifo_empty ? pend_pc : fifo_pc[head];
    assign entry_pred = fifo_empty ? bp_prediction : fifo_pred[head];

    assign head_nxt = (head == LOG2DEPTH'(DEPTH - 1)) ? '0 : head + 1'b1;
    assign tail_nxt = (tail == LOG2DEPTH'(DEPTH - 1)) ? '0 : tail + 1'b1;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[tail]   <= pend_pc;
            fifo_pred[tail] <= bp_prediction;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            pend_v        <= 1'b0;
            pend_pc       <= '0;
            bp_result_rdy <= 1'b0;
            bp_result     <= 1'b0;
            bp_pc_result  <= '0;
            mispredict    <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (resolve_ok) begin
                bp_result_rdy <= 1'b1;
                bp_result     <= resolve_taken;
                bp_pc_result  <= entry_pc;
                mispredict    <= (resolve_taken != entry_pred);
            end else begin
                bp_result_rdy <= 1'b0;
                mispredict    <= 1'b0;
            end
            if (resolve_valid && occ == '0)
                err_underflow <= 1'b1;

            if (squash) begin
                head   <= '0;
                tail   <= '0;
                count  <= '0;
                pend_v <= 1'b0;
            end else begin
                if (pop)
                    head <= head_nxt;
                if (push)
                    tail <= tail_nxt;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
                pend_v <= accept;
            end
            if (accept)
                pend_pc <= fetch_pc;
        end
    end

`ifdef BPRED_TRACKER_STATS_EN
    logic [15:0] br_cnt;
    logic [15:0] mp_cnt;

    // Counters saturate rather than wrap and are deliberately untouched by squash.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            if (resolve_ok && br_cnt != 16'hFFFF)
                br_cnt <= br_cnt + 16'd1;
            if (resolve_ok && (resolve_taken != entry_pred) && mp_cnt != 16'hFFFF)
                mp_cnt <= mp_cnt + 16'd1;
        end
    end

    assign stat_branches    = br_cnt;
    assign stat_mispredicts = mp_cnt;
`else
    assign stat_branches    = 16'd0;
    assign stat_mispredicts = 16'd0;
`endif

endmodule

// File: tb/tb_bpred_tracker.sv
// tb/tb_bpred_tracker.sv - scoreboard bench for bpred_tracker against a queue-based reference model
module tb_bpred_tracker;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fetch_branch = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        stall_fetch, pred_valid, pred_taken;
    logic        resolve_valid = 1'b0, resolve_taken = 1'b0, squash = 1'b0;
    logic        mispredict, err_underflow, bp_predict;
    logic [31:0] bp_pc_predict;
    logic        bp_prediction = 1'b0;
    logic        bp_result_rdy, bp_result;
    logic [31:0] bp_pc_result;
    logic [15:0] stat_branches, stat_mispredicts;

    bpred_tracker #(.PCWIDTH(32), .DEPTH(4), .LOG2DEPTH(2)) dut (
        .clk(clk), .resetn(resetn),
        .fetch_branch(fetch_branch), .fetch_pc(fetch_pc), .stall_fetch(stall_fetch),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .squash(squash),
        .mispredict(mispredict), .err_underflow(err_underflow),
        .bp_predict(bp_predict), .bp_pc_predict(bp_pc_predict), .bp_prediction(bp_prediction),
        .bp_result_rdy(bp_result_rdy), .bp_result(bp_result), .bp_pc_result(bp_pc_result),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit pred; } ent_t;
    typedef struct { logic [31:0] pc; bit taken; bit mis; } res_t;

    ent_t inflight[$];
    res_t expq[$];
    bit   pend_m = 0;
    bit   err_m = 0;
    int   nb = 0, nm = 0;
    int   total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn) begin
            if (bp_result_rdy) begin
                if (expq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    res_t r;
                    r = expq.pop_front();
                    chk("res_pc", bp_pc_result, r.pc);
                    chk("res_taken", bp_result, r.taken);
                    chk("res_mispredict", mispredict, r.mis);
                end
            end else if (mispredict) begin
                chk("mispredict_without_rdy", mispredict, 0);
            end
        end
    end

    task automatic check_stats();
`ifdef BPRED_TRACKER_STATS_EN
        chk("stat_branches", stat_branches, (nb > 16'hFFFF) ? 16'hFFFF : nb[15:0]);
        chk("stat_mispredicts", stat_mispredicts, (nm > 16'hFFFF) ? 16'hFFFF : nm[15:0]);
`else
        chk("stat_branches", stat_branches, 0);
        chk("stat_mispredicts", stat_mispredicts, 0);
`endif
    endtask

    task automatic step(input bit fb, input logic [31:0] pc, input bit rv, input bit rt,
                        input bit sq, input bit pr);
        bit exp_stall, acc;
        @(negedge clk);
        chk("err_underflow", err_underflow, err_m);
        check_stats();
        fetch_branch  = fb;
        fetch_pc      = pc;
        resolve_valid = rv;
        resolve_taken = rt;
        squash        = sq;
        bp_prediction = pend_m ? inflight[$].pred : 1'($urandom);
        #1;
        exp_stall = (inflight.size() >= 4);
        acc = fb && !exp_stall && !sq;
        chk("stall_fetch", stall_fetch, exp_stall);
        chk("pred_valid", pred_valid, pend_m);
        if (pend_m) chk("pred_taken", pred_taken, inflight[$].pred);
        chk("bp_predict", bp_predict, acc);
        chk("bp_pc_predict", bp_pc_predict, pc);
        if (rv) begin
            if (inflight.size() == 0) begin
                err_m = 1;
            end else begin
                ent_t e;
                res_t r;
                e = inflight.pop_front();
                r.pc = e.pc; r.taken = rt; r.mis = (rt != e.pred);
                expq.push_back(r);
                nb++;
                if (r.mis) nm++;
            end
        end
        if (sq) inflight.delete();
        if (acc) begin
            ent_t n;
            n.pc = pc; n.pred = pr;
            inflight.push_back(n);
        end
        pend_m = acc;
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        fetch_branch = 0; resolve_valid = 0; squash = 0;
        fetch_pc = $urandom;
        inflight.delete(); expq.delete();
        pend_m = 0; err_m = 0; nb = 0; nm = 0;
        #1;
        chk("rst_result_rdy", bp_result_rdy, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_stall", stall_fetch, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pc_result", bp_pc_result, 0);
        chk("rst_pc_predict", bp_pc_predict, fetch_pc);
        check_stats();
        @(negedge clk);
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        do_reset();
        // Basic accept and mispredicted resolve
        step(1, 32'h100, 0, 0, 0, 1);
        idle();
        idle();
        step(0, 32'h0, 1, 0, 0, 0);
        idle();
        // Fill to DEPTH, try a fifth, then drain in order
        step(1, 32'h300, 0, 0, 0, 0);
        step(1, 32'h304, 0, 0, 0, 1);
        step(1, 32'h308, 0, 0, 0, 1);
        step(1, 32'h30c, 0, 0, 0, 0);
        step(1, 32'h310, 0, 0, 0, 1);
        step(1, 32'h310, 1, 1, 0, 1);
        step(1, 32'h314, 0, 0, 0, 0);
        step(0, 32'h0, 1, 0, 0, 0);
        step(0, 32'h0, 1, 1, 0, 0);
        step(0, 32'h0, 1, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0, 0);
        idle();
        // Pending bypass
        step(1, 32'h200, 0, 0, 0, 1);
        step(0, 32'h0, 1, 1, 0, 0);
        idle();
        // Squash with same-cycle resolve and fetch
        step(1, 32'h400, 0, 0, 0, 0);
        step(1, 32'h404, 0, 0, 0, 1);
        step(1, 32'h408, 0, 0, 0, 0);
        idle();
        step(1, 32'h40c, 1, 1, 1, 1);
        idle();
        // Underflow, sticky
        step(0, 32'h0, 1, 1, 0, 0);
        idle();
        idle();
        // Randomized traffic with occasional mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 6, $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 9) < 4, 1'($urandom),
                     $urandom_range(0, 19) == 0, 1'($urandom));
            end
        end
        step(0, 32'h0, 0, 0, 1, 0);
        idle();
        idle();
        chk("results_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/bpred_tracker.md
# bpred_tracker

In-flight branch tracker that drives the scalar pipeline's 1-bit branch predictor from both ends. It issues prediction requests for fetched branches and returns each prediction to fetch one cycle later. It queues each {PC, prediction} until execute resolves the branch, then writes the actual outcome back to the predictor and flags mispredictions. It sits between fetch, execute and `branchpredict`.

## Interface
- `PCWIDTH`, 32, PC width
- `DEPTH`, 4, max in-flight predicted branches (FIFO plus pending stage)
- `LOG2DEPTH`, 2, log2(DEPTH); counters are LOG2DEPTH+1 bits

- `clk`  in  1  clock
- `resetn`  in  1  asynchronous, active-low reset
- `fetch_branch`  in  1  fetch holds a branch at `fetch_pc` this cycle
- `fetch_pc`  in  PCWIDTH  PC of that branch
- `stall_fetch`  out  1  tracker full; fetch must hold its branch
- `pred_valid`  out  1  prediction for the branch accepted last cycle is valid
- `pred_taken`  out  1  that prediction (1 = taken)
- `resolve_valid`  in  1  execute resolved the oldest in-flight branch
- `resolve_taken`  in  1  actual outcome
- `squash`  in  1  discard all in-flight branches
- `mispredict`  out  1  registered pulse: resolved outcome differed from prediction
- `err_underflow`  out  1  sticky: resolve arrived with nothing in flight
- `bp_predict`  out  1  to predictor `predict`
- `bp_pc_predict`  out  PCWIDTH  to predictor `pc_predict`
- `bp_prediction`  in  1  from predictor `prediction`, valid the cycle after `bp_predict`
- `bp_result_rdy`, `bp_result`  out  1 each  to predictor `result_rdy`, `result`
- `bp_pc_result`  out  PCWIDTH  to predictor `pc_result`
- `stat_branches`, `stat_mispredicts`  out  16 each  statistics (see Configuration)

## Operation
- Occupancy `occ` = FIFO count + `pend_v`. `stall_fetch` = (`occ` >= DEPTH). This is combinational and ignores a same-cycle pop.
- Accept: `bp_predict` = `fetch_branch` & ~`stall_fetch` & ~`squash`. `bp_pc_predict` = `fetch_pc` (combinational). On accept, the edge loads `pend_v`=1 and `pend_pc`=`fetch_pc`.
- Return: while `pend_v`=1, `pred_valid`=1 and `pred_taken`=`bp_prediction` (combinational). At the next edge, {`pend_pc`, `bp_prediction`} is pushed at the FIFO tail. `pend_v` clears unless a new accept reloads it.
- Resolve: pops the FIFO head. If the FIFO is empty but `pend_v`=1, resolve bypasses to the pending entry using `pend_pc`/`bp_prediction`, and that entry is not pushed.
- On resolve, the following registers load: `bp_result_rdy`=1, `bp_result`=`resolve_taken`, `bp_pc_result`=entry PC, `mispredict`=(`resolve_taken` != entry prediction).
- Resolve with `occ`=0: ignored, no update, `err_underflow` set. It clears only on reset.
- Push and pop in the same cycle: both occur and count is unchanged. Head/tail pointers wrap modulo DEPTH.
- Squash: a same-cycle resolve is processed first (update and mispredict are still issued). Then the FIFO, pointers and `pend_v` clear at the edge. A same-cycle fetch is not accepted.

## Timing
- Reset values: all registered outputs 0, `occ`=0, `err_underflow`=0, stats 0. The combinational outputs then follow their inputs: `bp_pc_predict`=`fetch_pc`, `stall_fetch`=0, `pred_valid`=0.
- Accept at cycle N gives `pred_valid` in cycle N+1 and a FIFO push at the end of N+1.
- Resolve at cycle R gives `bp_result_rdy`, `mispredict` and the result in cycle R+1, each as a one-cycle pulse.
- Back-to-back accepts are allowed every cycle while not full. Throughput is one branch per cycle.
- Mid-operation reset clears all state immediately. No predictor update is issued for lost entries.

## Configuration
- `BPRED_TRACKER_STATS_EN` defined: `stat_branches` increments on every valid resolve and `stat_mispredicts` on every mispredict. Both are 16-bit, saturate at 0xFFFF, and are unaffected by squash.
- Not defined: both stat ports are tied to 0 and no counter logic is built.

## Test plan
- Reset, then accept PC 0x100 with `bp_prediction`=1 → `pred_valid`=1 and `pred_taken`=1 next cycle; `occ`=1 after push.
- Resolve 0x100 with `resolve_taken`=0 → next cycle `bp_result_rdy`=1, `bp_result`=0, `bp_pc_result`=0x100, `mispredict`=1; `occ`=0.
- Accept 4 branches back-to-back (DEPTH=4) → `stall_fetch`=1 once `occ`=4. Resolve one → `stall_fetch` drops the following cycle, and the results come out in fetch order.
- Accept 0x200, then resolve in the very next cycle (pending bypass) → `bp_pc_result`=0x200 using the live `bp_prediction`; no FIFO push.
- Three in flight, `squash` together with `resolve_valid` → one update issued for the oldest entry, `occ`=0 after the edge, and the same-cycle `fetch_branch` is not accepted.
- Resolve with `occ`=0 → no `bp_result_rdy`, and `err_underflow`=1 stays high. With the stats macro, after 5 resolves and 2 mispredicts → `stat_branches`=5, `stat_mispredicts`=2.
